// File: rtl/mips_trace_pkg.sv
// Shared definitions for the PC trace buffer.
//   trace_state_e : capture FSM encoding (IDLE, WAIT_TRIG, RUN, STOP)
//   HALT_INSTR    : syscall-halt instruction word that ends a capture run
//   trace_entry_t : one FIFO record {pc, instr, seq}
package mips_trace_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    RUN       = 2'd2,
    STOP      = 2'd3
  } trace_state_e;

  localparam logic [31:0] HALT_INSTR = 32'h0000_000C;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [15:0] seq;
  } trace_entry_t;

  localparam int ENTRY_W = $bits(trace_entry_t);

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO with synchronous flush.
//   clk, rst    : clock, asynchronous active-low reset
//   flush       : empties the FIFO; dominates push/pop in the same cycle
//   push, wdata : write request; accepted when not full, or when full and
//                 a pop happens in the same cycle
//   pop         : read request; ignored while empty
//   rdata       : head entry (all zeros while empty)
//   valid       : FIFO non-empty
//   full        : FIFO holds DEPTH entries
//   count       : occupancy, 0..DEPTH
module trace_fifo #(
  parameter int WIDTH = 80,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra MSB: equal pointers mean empty, pointers that
  // differ only in the MSB mean full.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign valid = !empty;
  assign count = wr_ptr - rd_ptr;
  // Gating the head with empty gives all-zero outputs after reset without
  // having to reset the storage array.
  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples its inputs from before the clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array has no reset; pointers alone decide which
  // entries are meaningful, and an unreset array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/pc_trace_buffer.sv
// Retired-instruction trace buffer. Once armed (trace_en) it waits for a
// retire at trig_pc, then records {pc, instr, seq} of every retire into a
// FWFT FIFO until a syscall-halt is captured (or, with STOP_ON_FULL, until
// the first drop). Entries that do not fit are dropped and counted.
//   clk, rst                       : clock, asynchronous active-low reset
//   trace_en                       : arm capture; low forces IDLE
//   trig_pc                        : PC that starts capture
//   clear                          : synchronous flush of FIFO, seq, flags
//   cap_valid, cap_pc, cap_instr   : retire port
//   out_valid, out_ready           : head handshake
//   out_pc, out_instr, out_seq     : head entry
//   count                          : FIFO occupancy
//   overflow                       : sticky, an entry was dropped
//   drop_cnt                       : dropped entries, saturating
//   state                          : current FSM state
module pc_trace_buffer
  import mips_trace_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter bit STOP_ON_FULL = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   trace_en,
  input  logic [31:0]            trig_pc,
  input  logic                   clear,
  input  logic                   cap_valid,
  input  logic [31:0]            cap_pc,
  input  logic [31:0]            cap_instr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_instr,
  output logic [15:0]            out_seq,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [15:0]            drop_cnt,
  output logic [1:0]             state
);

  trace_state_e cur_state;
  trace_state_e nxt_state;
  trace_entry_t wr_entry;
  trace_entry_t rd_entry;
  logic [15:0]  seq;
  logic         capture;
  logic         pop;
  logic         fifo_full;
  logic         drop;
  logic         is_halt;

  // A retire is eligible in RUN, and in WAIT_TRIG when it is the trigger
  // itself. Clear and a disarm in the same cycle suppress it.
  assign capture = trace_en && !clear && cap_valid &&
                   ((cur_state == RUN) ||
                    ((cur_state == WAIT_TRIG) && (cap_pc == trig_pc)));
  assign pop      = out_valid && out_ready;
  // A simultaneous pop frees the slot, so only full-without-pop drops.
  assign drop     = capture && fifo_full && !pop;
  assign is_halt  = (cap_instr == HALT_INSTR);
  assign wr_entry = '{pc: cap_pc, instr: cap_instr, seq: seq};

  trace_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (clear),
    .push  (capture),
    .wdata (wr_entry),
    .pop   (out_ready),
    .rdata (rd_entry),
    .valid (out_valid),
    .full  (fifo_full),
    .count (count)
  );

  assign out_pc    = rd_entry.pc;
  assign out_instr = rd_entry.instr;
  assign out_seq   = rd_entry.seq;
  assign state     = cur_state;

  // NOTE: every signal driven in an always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      IDLE:      nxt_state = WAIT_TRIG;
      WAIT_TRIG: if (capture) nxt_state = RUN;
      default:   nxt_state = cur_state;
    endcase
    if (capture && (is_halt || (STOP_ON_FULL && drop))) nxt_state = STOP;
    // Disarm and clear override everything, including the STOP hold.
    if (clear || !trace_en) nxt_state = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cur_state <= IDLE;
    else      cur_state <= nxt_state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seq      <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clear) begin
      seq      <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      // Sequence numbers advance for dropped entries too, so gaps in the
      // drained stream show exactly where data was lost.
      if (capture) seq <= seq + 16'd1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pc_trace_buffer.sv
// Self-checking bench for pc_trace_buffer: directed scenarios followed by a
// randomized run, all compared against a queue-based reference model.
module tb_pc_trace_buffer;

  localparam int DEPTH        = 16;
  localparam bit STOP_ON_FULL = 1'b0;
  localparam int CW           = $clog2(DEPTH) + 1;

  localparam int S_IDLE = 0;
  localparam int S_WAIT = 1;
  localparam int S_RUN  = 2;
  localparam int S_STOP = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          trace_en;
  logic [31:0]   trig_pc;
  logic          clear;
  logic          cap_valid;
  logic [31:0]   cap_pc;
  logic [31:0]   cap_instr;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc;
  logic [31:0]   out_instr;
  logic [15:0]   out_seq;
  logic [CW-1:0] count;
  logic          overflow;
  logic [15:0]   drop_cnt;
  logic [1:0]    state;

  pc_trace_buffer #(
    .DEPTH        (DEPTH),
    .STOP_ON_FULL (STOP_ON_FULL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .trace_en  (trace_en),
    .trig_pc   (trig_pc),
    .clear     (clear),
    .cap_valid (cap_valid),
    .cap_pc    (cap_pc),
    .cap_instr (cap_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_seq   (out_seq),
    .count     (count),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
    .state     (state)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of captured records plus the visible flags.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [15:0] seq;
  } m_entry_t;

  m_entry_t    mq[$];
  int unsigned m_seq;
  bit          m_ovf;
  int          m_drops;
  int          m_state;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_seq   = 0;
    m_ovf   = 1'b0;
    m_drops = 0;
    m_state = S_IDLE;
  endtask

  // Applies one clock edge of spec behaviour using the inputs held across it.
  task automatic model_clock();
    bit cap;
    bit dropped;
    if (clear) begin
      model_reset();
      return;
    end
    cap = trace_en && cap_valid &&
          (m_state == S_RUN || (m_state == S_WAIT && cap_pc == trig_pc));
    if (out_ready && mq.size() > 0) void'(mq.pop_front());
    if (!trace_en)               m_state = S_IDLE;
    else if (m_state == S_IDLE)  m_state = S_WAIT;
    else if (m_state == S_WAIT && cap) m_state = S_RUN;
    if (cap) begin
      dropped = (mq.size() >= DEPTH);
      if (!dropped) begin
        mq.push_back('{pc: cap_pc, instr: cap_instr, seq: 16'(m_seq)});
      end else begin
        m_ovf = 1'b1;
        if (m_drops < 65535) m_drops++;
      end
      m_seq = (m_seq + 1) % 65536;
      if (cap_instr == 32'h0000_000C || (STOP_ON_FULL && dropped)) m_state = S_STOP;
    end
  endtask

  task automatic compare_all();
    check("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    check("count",     32'(count),     32'(mq.size()));
    check("overflow",  32'(overflow),  32'(m_ovf));
    check("drop_cnt",  32'(drop_cnt),  32'(m_drops));
    check("state",     32'(state),     32'(m_state));
    if (mq.size() > 0) begin
      check("out_pc",    out_pc,         mq[0].pc);
      check("out_instr", out_instr,      mq[0].instr);
      check("out_seq",   32'(out_seq),   32'(mq[0].seq));
    end
  endtask

  // Inputs change only at the falling edge; the DUT is sampled there too.
  task automatic step();
    @(posedge clk);
    model_clock();
    @(negedge clk);
    compare_all();
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] instr);
    cap_valid = 1'b1;
    cap_pc    = pc;
    cap_instr = instr;
    step();
    cap_valid = 1'b0;
  endtask

  task automatic quiet(input int n);
    cap_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_pc"},    out_pc,         32'd0);
    check({tag, "_instr"}, out_instr,      32'd0);
    check({tag, "_seq"},   32'(out_seq),   32'd0);
    check({tag, "_count"}, 32'(count),     32'd0);
    check({tag, "_ovf"},   32'(overflow),  32'd0);
    check({tag, "_drops"}, 32'(drop_cnt),  32'd0);
    check({tag, "_state"}, 32'(state),     32'd0);
  endtask

  initial begin
    rst       = 1'b0;
    trace_en  = 1'b0;
    trig_pc   = 32'h0000_3000;
    clear     = 1'b0;
    cap_valid = 1'b0;
    cap_pc    = 32'd0;
    cap_instr = 32'd0;
    out_ready = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b1;
    quiet(2);

    // Trigger capture: the pre-trigger retire is ignored.
    trace_en = 1'b1;
    quiet(1);
    retire(32'h0000_2FFC, 32'h2408_0001);
    retire(32'h0000_3000, 32'h2408_0002);
    retire(32'h0000_3004, 32'h2408_0003);
    check("trig_count", 32'(count),   32'd2);
    check("trig_state", 32'(state),   32'd2);
    check("trig_seq0",  32'(out_seq), 32'd0);
    check("trig_pc0",   out_pc,       32'h0000_3000);
    out_ready = 1'b1;
    quiet(1);
    check("trig_seq1",  32'(out_seq), 32'd1);
    check("trig_pc1",   out_pc,       32'h0000_3004);
    quiet(1);

    // Overflow: 20 captures into 16 slots with the consumer stalled.
    out_ready = 1'b0;
    do_clear();
    quiet(1);
    for (int i = 0; i < 20; i++) retire(32'h0000_3000 + 32'(4 * i), 32'h0100_0000 + 32'(i));
    check("ovf_count", 32'(count),    32'd16);
    check("ovf_flag",  32'(overflow), 32'd1);
    check("ovf_drops", 32'(drop_cnt), 32'd4);

    // Full with simultaneous push and pop; the new entry carries seq 20.
    out_ready = 1'b1;
    retire(32'h0000_3050, 32'h0100_0014);
    out_ready = 1'b0;
    check("pp_count", 32'(count),    32'd16);
    check("pp_drops", 32'(drop_cnt), 32'd4);
    check("pp_head",  32'(out_seq),  32'd1);
    out_ready = 1'b1;
    quiet(16);
    check("pp_drained", 32'(out_valid), 32'd0);

    // Halt instruction ends the run and later retires are ignored.
    out_ready = 1'b0;
    do_clear();
    quiet(1);
    for (int i = 0; i < 4; i++) retire(32'h0000_3000 + 32'(4 * i), 32'h0000_0020);
    retire(32'h0000_3010, 32'h0000_000C);
    check("halt_state", 32'(state), 32'd3);
    check("halt_count", 32'(count), 32'd5);
    for (int i = 0; i < 3; i++) retire(32'h0000_3014 + 32'(4 * i), 32'h0000_0020);
    check("halt_hold", 32'(count), 32'd5);

    // Asynchronous reset mid-run with five entries queued.
    do_clear();
    quiet(1);
    for (int i = 0; i < 5; i++) retire(32'h0000_3000 + 32'(4 * i), 32'h0000_0020);
    check("mid_count", 32'(count), 32'd5);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("arst");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    quiet(1);

    // Clear with eight entries and overflow set; clear beats push and pop.
    for (int i = 0; i < 17; i++) retire(32'h0000_3000 + 32'(4 * i), 32'h0000_0020);
    out_ready = 1'b1;
    quiet(8);
    out_ready = 1'b0;
    check("clr_pre_count", 32'(count),    32'd8);
    check("clr_pre_ovf",   32'(overflow), 32'd1);
    out_ready = 1'b1;
    cap_valid = 1'b1;
    cap_pc    = 32'h0000_4000;
    clear     = 1'b1;
    step();
    clear     = 1'b0;
    cap_valid = 1'b0;
    check("clr_count", 32'(count),    32'd0);
    check("clr_ovf",   32'(overflow), 32'd0);
    check("clr_drops", 32'(drop_cnt), 32'd0);
    check("clr_state", 32'(state),    32'd0);

    // Randomized traffic in phases of varying consumer throughput.
    for (int phase = 0; phase < 12; phase++) begin
      int ready_pct;
      ready_pct = (phase % 3 == 0) ? 10 : ((phase % 3 == 1) ? 50 : 95);
      for (int c = 0; c < 250; c++) begin
        int pick;
        clear     = ($urandom_range(0, 299) == 0);
        trace_en  = ($urandom_range(0, 39) != 0);
        cap_valid = ($urandom_range(0, 2) != 0);
        pick      = $urandom_range(0, 3);
        cap_pc    = (pick == 0) ? trig_pc :
                    (pick == 1) ? trig_pc + 32'd4 : {$urandom_range(0, 65535), 2'b00};
        cap_instr = ($urandom_range(0, 29) == 0) ? 32'h0000_000C : $urandom;
        out_ready = ($urandom_range(0, 99) < ready_pct);
        step();
      end
    end
    clear     = 1'b0;
    cap_valid = 1'b0;
    out_ready = 1'b1;
    quiet(DEPTH + 2);
    check("final_empty", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_trace_buffer.md
PC_TRACE_BUFFER -- requirements
Module: pc_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, 4..64).
REQ-002 SHALL have parameter STOP_ON_FULL, default 0; 1 = stop capture at first drop.
REQ-003 SHALL have port clk  input  1  single clock, rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port trace_en  input  1  arm capture; 0 forces IDLE.
REQ-006 SHALL have port trig_pc  input  32  PC that starts capture.
REQ-007 SHALL have port clear  input  1  synchronous flush of FIFO, counters, flags.
REQ-008 SHALL have port cap_valid  input  1  one instruction retires this cycle.
REQ-009 SHALL have port cap_pc  input  32  PC of retiring instruction.
REQ-010 SHALL have port cap_instr  input  32  IR of retiring instruction.
REQ-011 SHALL have port out_valid  output  1  head entry available.
REQ-012 SHALL have port out_ready  input  1  consumer accepts head.
REQ-013 SHALL have port out_pc  output  32  head PC.
REQ-014 SHALL have port out_instr  output  32  head IR.
REQ-015 SHALL have port out_seq  output  16  head sequence number.
REQ-016 SHALL have port count  output  log2(DEPTH)+1  FIFO occupancy.
REQ-017 SHALL have port overflow  output  1  sticky, an entry was dropped.
REQ-018 SHALL have port drop_cnt  output  16  dropped entries, saturating.
REQ-019 SHALL have port state  output  2  current FSM state.

Function
REQ-020 SHALL implement states IDLE=0, WAIT_TRIG=1, RUN=2, STOP=3.
REQ-021 SHALL move IDLE->WAIT_TRIG when trace_en=1; any state->IDLE when trace_en=0 (FIFO contents kept, drainable).
REQ-022 SHALL move WAIT_TRIG->RUN on cap_valid with cap_pc==trig_pc; that triggering instruction SHALL be captured.
REQ-023 SHALL move RUN->STOP after capturing cap_instr==32'h0000000C (syscall halt), or on a drop when STOP_ON_FULL=1; STOP leaves only via trace_en=0 or clear.
REQ-024 SHALL push {cap_pc, cap_instr, seq} on every cap_valid in RUN (and the trigger cycle); no push in IDLE/WAIT_TRIG/STOP.
REQ-025 SHALL increment internal seq on every eligible retire, pushed or dropped; 16-bit wrap FFFF->0000; seq=0 at first capture after reset/clear.
REQ-026 SHALL be first-word-fall-through: out_* valid in the cycle after the push that makes FIFO non-empty; pop when out_valid&&out_ready.
REQ-027 SHALL, when full and a push occurs without pop, drop the new entry, set overflow, increment drop_cnt (saturate at FFFF).
REQ-028 SHALL, when full with simultaneous push and pop, perform both; no drop, count unchanged.
REQ-029 SHALL, when empty with simultaneous push and pop, ignore pop (out_valid=0); push lands.
REQ-030 SHALL keep out_pc/out_instr/out_seq stable while out_valid=1 and out_ready=0.
REQ-031 SHALL on clear: empty FIFO, seq=0, overflow=0, drop_cnt=0, state=IDLE next cycle; clear dominates simultaneous push/pop.
REQ-032 SHALL wrap read/write pointers modulo DEPTH with an extra MSB for full/empty distinction.

Reset
REQ-033 SHALL on rst=0 asynchronously set: state=IDLE, count=0, out_valid=0, out_pc=0, out_instr=0, out_seq=0, overflow=0, drop_cnt=0, seq=0, pointers=0.
REQ-034 SHALL discard in-flight capture and FIFO contents on reset mid-operation; first clk edge after rst=1 behaves as from IDLE.

Structure
REQ-035 SHALL place state encodings and HALT_INSTR=32'h0000000C in shared package mips_trace_pkg.
REQ-036 SHALL use one sub-module, trace_fifo (parameterized width/depth FWFT FIFO); FSM, seq and counters in the top.

Verification
REQ-037 SHALL verify: trig_pc=0x3000, retires at 0x2FFC,0x3000,0x3004 -> two entries, seq 0,1, state RUN.
REQ-038 SHALL verify: DEPTH=16, out_ready=0, 20 retires in RUN -> count=16, overflow=1, drop_cnt=4, seq of last retire=19.
REQ-039 SHALL verify: full FIFO, push and pop same cycle -> count stays 16, drop_cnt unchanged, head advances by one.
REQ-040 SHALL verify: retire cap_instr=0x0000000C at PC 0x3010 -> captured, state=STOP, later retires ignored.
REQ-041 SHALL verify: rst asserted low mid-RUN with count=5 -> outputs immediately at reset values, state=IDLE.
REQ-042 SHALL verify: clear with count=8, overflow=1 -> next cycle count=0, overflow=0, drop_cnt=0, state=IDLE.
